// File: rtl/data_mem_responder_if.sv
// Request/response bus between an initiator (master) and the data memory responder (slave).
// One request in flight at a time; both channels use valid/ready handshakes.
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Word-organised data memory with byte-lane stores, a fixed number of wait states
// per access and a single outstanding request (IDLE -> BUSY -> RESP).
module data_mem_responder #(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    data_mem_responder_if.slave bus
);

    localparam int unsigned    AW         = $clog2(DEPTH);
    localparam int unsigned    CW         = (WAIT_CYCLES == 0) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_INIT   = CW'(WAIT_CYCLES);
    localparam logic [32:0]    ADDR_LIMIT = 33'(DEPTH) << 2;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [CW-1:0]  cnt;

    logic           lat_write;
    logic [31:0]    lat_addr;
    logic [31:0]    lat_wdata;
    logic [3:0]     lat_wstrb;

    logic [31:0]    rdata_q;
    logic           err_q;

    logic [31:0]    mem [DEPTH];

    logic           accept;
    logic           access;
    logic           addr_err;
    logic [AW-1:0]  word_idx;

    assign accept   = bus.req_valid && bus.req_ready;
    assign access   = (state == BUSY) && (cnt == '0);
    assign word_idx = lat_addr[AW+1:2];
    assign addr_err = (lat_addr[1:0] != 2'b00) || ({1'b0, lat_addr} >= ADDR_LIMIT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept)          state_nxt = BUSY;
            BUSY:    if (cnt == '0)       state_nxt = RESP;
            RESP:    if (bus.resp_ready)  state_nxt = IDLE;
            default:                      state_nxt = IDLE;
        endcase
    end

    // req_ready also depends on reset directly so it drops the moment reset asserts.
    always_comb begin
        bus.req_ready  = (state == IDLE) && reset;
        bus.resp_valid = (state == RESP);
        bus.resp_rdata = rdata_q;
        bus.resp_err   = err_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_wstrb <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            if (accept) begin
                lat_write <= bus.req_write;
                lat_addr  <= bus.req_addr;
                lat_wdata <= bus.req_wdata;
                lat_wstrb <= bus.req_wstrb;
                cnt       <= CNT_INIT;
            end else if ((state == BUSY) && (cnt != '0)) begin
                cnt <= cnt - CW'(1);
            end

            if (access) begin
                if (addr_err) begin
                    rdata_q <= '0;
                    err_q   <= 1'b1;
                end else if (lat_write) begin
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                end else begin
                    rdata_q <= mem[word_idx];
                    err_q   <= 1'b0;
                end
            end
        end
    end

    // Storage is deliberately outside the reset domain: contents survive reset.
    always_ff @(posedge clk) begin
        if (access && lat_write && !addr_err) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (lat_wstrb[i]) mem[word_idx][8*i +: 8] <= lat_wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256: number of 32-bit words stored, a power of two, at least 2.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2: wait states inserted before each access, 0 to 15.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port req_valid, input, 1 bit: initiator presents a request.
REQ-006 SHALL have port req_ready, output, 1 bit: responder can accept a request.
REQ-007 SHALL have port req_write, input, 1 bit: 1 = store, 0 = load.
REQ-008 SHALL have port req_addr, input, 32 bits: byte address.
REQ-009 SHALL have port req_wdata, input, 32 bits: store data.
REQ-010 SHALL have port req_wstrb, input, 4 bits: byte-lane enables for a store; bit i enables byte i.
REQ-011 SHALL have port resp_valid, output, 1 bit: response available.
REQ-012 SHALL have port resp_ready, input, 1 bit: initiator accepts the response.
REQ-013 SHALL have port resp_rdata, output, 32 bits: load data.
REQ-014 SHALL have port resp_err, output, 1 bit: the access was rejected.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, BUSY, RESP.
REQ-016 SHALL drive req_ready=1 only in IDLE with reset deasserted, and resp_valid=1 only in RESP.
REQ-017 SHALL accept a request on any edge with req_valid=1 and req_ready=1, as follows:
- latch req_write, req_addr, req_wdata and req_wstrb;
- load the wait counter with WAIT_CYCLES;
- enter BUSY.
REQ-018 SHALL behave as follows in BUSY:
- counter != 0: decrement the counter;
- counter == 0: perform the access, register its results, enter RESP.
REQ-019 SHALL assert resp_valid exactly WAIT_CYCLES+1 edges after the accept edge; with WAIT_CYCLES=0 that is the next edge.
REQ-020 SHALL hold resp_valid, resp_rdata and resp_err stable in RESP until an edge with resp_ready=1, then return to IDLE.
REQ-021 SHALL never accept a request while in BUSY or RESP; requests are not pipelined, and the minimum request-to-request spacing is WAIT_CYCLES+3 cycles.
REQ-022 SHALL use word index req_addr[log2(DEPTH)+1:2].
REQ-023 SHALL treat req_addr[1:0] != 0 as misaligned and req_addr >= DEPTH*4 as out of range.
REQ-024 SHALL, for a misaligned or out-of-range access: set resp_err=1 and resp_rdata=0, and leave memory unmodified.
REQ-025 SHALL, for a valid store: write only the byte lanes with req_wstrb set, then return resp_rdata=0 and resp_err=0.
REQ-026 SHALL treat a valid store with req_wstrb=0 as a no-op that still receives a normal response.
REQ-027 SHALL, for a valid load: return the full stored word on resp_rdata with resp_err=0; req_wstrb is ignored.
REQ-028 SHALL ignore request inputs in BUSY and RESP; changes there do not alter the latched request.
REQ-029 SHALL make the wait counter width max(1, ceil(log2(WAIT_CYCLES+1))) bits; it never wraps.

Reset
REQ-030 SHALL, while reset=0, asynchronously force:
- state to IDLE, counter to 0;
- req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0.
REQ-031 SHALL abort any request in BUSY or RESP when reset is asserted mid-operation:
- a store not yet performed SHALL NOT be performed;
- a response not yet taken SHALL be discarded.
REQ-032 SHALL NOT clear memory contents on reset.
REQ-033 SHALL drive req_ready=1 on the first cycle after reset deasserts.

Verification
REQ-034 SHALL cover a basic store/load: store 0xDEADBEEF, wstrb=0xF, addr 0x10; then load 0x10 -> rdata 0xDEADBEEF, err=0, resp_valid 3 edges after each accept (WAIT_CYCLES=2).
REQ-035 SHALL cover byte lanes: store 0x11223344, wstrb=0x5, addr 0x10 over 0xDEADBEEF; load -> rdata 0xDE22BE44.
REQ-036 SHALL cover errors:
- load addr 0x13 (misaligned) -> err=1, rdata=0;
- store addr 0x400 with DEPTH=256 -> err=1, and memory unchanged.
REQ-037 SHALL cover backpressure: hold resp_ready=0 for 5 cycles -> resp_valid and rdata stable and req_ready=0 throughout; resp_ready=1 -> IDLE, req_ready=1 next cycle.
REQ-038 SHALL cover reset during BUSY: store 0xCAFEBABE to 0x20, reset asserted one edge after accept -> outputs at reset values immediately; load 0x20 -> previous contents.
REQ-039 SHALL cover WAIT_CYCLES=0: accept at edge N -> resp_valid after edge N+1.
